// File: rtl/usrt_rx.sv
// Synchronous serial receiver: samples i_Rx on rising edges of an external bit clock,
// deframes start/data/[parity]/stop and holds one received word for the host.
module usrt_rx #(
    parameter int DATA_BITS = 8,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic                 i_Pclk,
    input  logic                 i_Reset,
    input  logic                 i_Sclk,
    input  logic                 i_Rx,
    input  logic                 i_Read,
    output logic [DATA_BITS-1:0] o_Data,
    output logic                 o_Valid,
    output logic                 o_Ready,
    output logic                 o_Busy,
    output logic                 o_FrameErr,
    output logic                 o_ParErr,
    output logic                 o_Overrun
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_bit;
    logic                   sclk_s1, sclk_s2, sclk_d;
    logic                   rx_s1, rx_s2;

    logic smp_edge, stop_edge, par_bad, good, load, read_ok;
    logic set_fe, set_pe, set_ov;

    assign smp_edge  = sclk_s2 & ~sclk_d;
    assign stop_edge = smp_edge & (state == STOP);
    assign par_bad   = PARITY_EN & ((^shift_reg) ^ par_bit);
    assign read_ok   = i_Read & o_Valid;

    // A stop bit of 0 masks any parity verdict; only clean frames reach the data register.
    assign set_fe = stop_edge & ~rx_s2;
    assign set_pe = stop_edge & rx_s2 & par_bad;
    assign good   = stop_edge & rx_s2 & ~par_bad;
    assign load   = good & (~o_Valid | i_Read);
    assign set_ov = good & o_Valid & ~i_Read;

    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            sclk_s1    <= 1'b0;
            sclk_s2    <= 1'b0;
            sclk_d     <= 1'b0;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            state      <= IDLE;
            bit_cnt    <= '0;
            o_Busy     <= 1'b0;
            o_Data     <= '0;
            o_Valid    <= 1'b0;
            o_Ready    <= 1'b0;
            o_FrameErr <= 1'b0;
            o_ParErr   <= 1'b0;
            o_Overrun  <= 1'b0;
        end else begin
            sclk_s1 <= i_Sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            rx_s1   <= i_Rx;
            rx_s2   <= rx_s1;

            case (state)
                IDLE: begin
                    if (smp_edge && !rx_s2) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        o_Busy  <= 1'b1;
                    end
                end
                DATA: begin
                    if (smp_edge) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= PARITY_EN ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (smp_edge) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Back to IDLE directly so a start bit on the very next edge is taken.
                    if (smp_edge) begin
                        state  <= IDLE;
                        o_Busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_Busy <= 1'b0;
                end
            endcase

            o_Ready <= read_ok;
            if (load) begin
                o_Data <= shift_reg;
            end
            o_Valid    <= load | (o_Valid & ~read_ok);
            o_FrameErr <= set_fe | (o_FrameErr & ~read_ok);
            o_ParErr   <= set_pe | (o_ParErr & ~read_ok);
            o_Overrun  <= set_ov | (o_Overrun & ~read_ok);
        end
    end

    // Datapath holding registers: no reset, contents are only consumed after a full frame.
    always_ff @(posedge i_Pclk) begin
        if (smp_edge && state == DATA) begin
            shift_reg <= {rx_s2, shift_reg[DATA_BITS-1:1]};
        end
        if (smp_edge && state == PARITY) begin
            par_bit <= rx_s2;
        end
    end

endmodule

// File: tb/tb_usrt_rx.sv
// Bench for usrt_rx: two instances (no parity / even parity) driven by randomized
// bit-clock frames and reads, checked every cycle against a frame-level model.
module tb_usrt_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] sclk_in, rx_in, rd_in;
    logic [7:0] data0, data1;
    logic [1:0] valid, ready, busy, fe, pe, ov;

    usrt_rx #(.DATA_BITS(8), .PARITY_EN(1'b0)) u0 (
        .i_Pclk(clk), .i_Reset(rst), .i_Sclk(sclk_in[0]), .i_Rx(rx_in[0]), .i_Read(rd_in[0]),
        .o_Data(data0), .o_Valid(valid[0]), .o_Ready(ready[0]), .o_Busy(busy[0]),
        .o_FrameErr(fe[0]), .o_ParErr(pe[0]), .o_Overrun(ov[0])
    );

    usrt_rx #(.DATA_BITS(8), .PARITY_EN(1'b1)) u1 (
        .i_Pclk(clk), .i_Reset(rst), .i_Sclk(sclk_in[1]), .i_Rx(rx_in[1]), .i_Read(rd_in[1]),
        .o_Data(data1), .o_Valid(valid[1]), .o_Ready(ready[1]), .o_Busy(busy[1]),
        .o_FrameErr(fe[1]), .o_ParErr(pe[1]), .o_Overrun(ov[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: line delay through the synchronizers, then a bit queue per frame.
    bit       m_sc1[2], m_sc2[2], m_scd[2], m_rx1[2], m_rx2[2];
    bit       m_coll[2];
    int       m_n[2];
    bit       m_bits[2][12];
    bit [7:0] m_data[2];
    bit       m_valid[2], m_ready[2], m_fe[2], m_pe[2], m_ov[2];
    bit       model_live = 1'b0;

    task automatic model_step(input int k);
        int       nbits;
        bit       e, r, rd, rok, good, sfe, spe, sov, load, stopb, pbad;
        bit [7:0] d;
        nbits = (k == 1) ? 10 : 9;
        good = 0; sfe = 0; spe = 0; d = '0;
        if (rst) begin
            m_sc1[k] = 0; m_sc2[k] = 0; m_scd[k] = 0; m_rx1[k] = 1; m_rx2[k] = 1;
            m_coll[k] = 0; m_n[k] = 0; m_data[k] = '0;
            m_valid[k] = 0; m_ready[k] = 0; m_fe[k] = 0; m_pe[k] = 0; m_ov[k] = 0;
            return;
        end
        e = m_sc2[k] & ~m_scd[k];
        r = m_rx2[k];
        m_scd[k] = m_sc2[k]; m_sc2[k] = m_sc1[k]; m_sc1[k] = sclk_in[k];
        m_rx2[k] = m_rx1[k]; m_rx1[k] = rx_in[k];
        rd  = rd_in[k];
        rok = rd & m_valid[k];
        if (e) begin
            if (!m_coll[k]) begin
                if (!r) begin
                    m_coll[k] = 1;
                    m_n[k] = 0;
                end
            end else begin
                m_bits[k][m_n[k]] = r;
                m_n[k]++;
                if (m_n[k] == nbits) begin
                    for (int i = 0; i < 8; i++) d[i] = m_bits[k][i];
                    stopb = m_bits[k][nbits-1];
                    pbad  = (k == 1) ? ((^d) ^ m_bits[k][8]) : 1'b0;
                    if (!stopb) sfe = 1;
                    else if (pbad) spe = 1;
                    else good = 1;
                    m_coll[k] = 0;
                end
            end
        end
        load = good && (!m_valid[k] || rd);
        sov  = good && m_valid[k] && !rd;
        m_ready[k] = rok;
        if (load) m_data[k] = d;
        m_valid[k] = load ? 1'b1 : (rok ? 1'b0 : m_valid[k]);
        m_fe[k] = sfe | (m_fe[k] & !rok);
        m_pe[k] = spe | (m_pe[k] & !rok);
        m_ov[k] = sov | (m_ov[k] & !rok);
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        if (rst) model_live = 1'b1;
        #1;
        if (model_live) begin
            check("cycle_u0", 32'({data0, valid[0], ready[0], busy[0], fe[0], pe[0], ov[0]}),
                  32'({m_data[0], m_valid[0], m_ready[0], m_coll[0], m_fe[0], m_pe[0], m_ov[0]}));
            check("cycle_u1", 32'({data1, valid[1], ready[1], busy[1], fe[1], pe[1], ov[1]}),
                  32'({m_data[1], m_valid[1], m_ready[1], m_coll[1], m_fe[1], m_pe[1], m_ov[1]}));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input int k, input bit b);
        rx_in[k]   = b;
        sclk_in[k] = 1'b0;
        wait_cyc($urandom_range(2, 5));
        sclk_in[k] = 1'b1;
        wait_cyc($urandom_range(2, 5));
    endtask

    task automatic send_frame(input int k, input logic [7:0] d, input bit par, input bit stopb);
        send_bit(k, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(k, d[i]);
        if (k == 1) send_bit(k, par);
        send_bit(k, stopb);
    endtask

    task automatic settle(input int k);
        sclk_in[k] = 1'b0;
        rx_in[k]   = 1'b1;
        wait_cyc(8);
    endtask

    task automatic pulse_read(input int k);
        rd_in[k] = 1'b1;
        wait_cyc(1);
        rd_in[k] = 1'b0;
    endtask

    bit done0 = 1'b0;
    bit done1 = 1'b0;

    task automatic rand_sender(input int k);
        logic [7:0] d;
        bit         stopb, par;
        repeat (25) begin
            d     = 8'($urandom);
            stopb = ($urandom_range(0, 7) != 0);
            par   = (^d) ^ ($urandom_range(0, 5) == 0);
            send_frame(k, d, par, stopb);
            repeat ($urandom_range(0, 2)) send_bit(k, 1'b1);
        end
        settle(k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sclk_in = 2'b00; rx_in = 2'b11; rd_in = 2'b00;
        @(negedge clk);
        wait_cyc(3);
        check("reset_u0", 32'({data0, valid[0], ready[0], busy[0], fe[0], pe[0], ov[0]}), 32'd0);
        check("reset_u1", 32'({data1, valid[1], ready[1], busy[1], fe[1], pe[1], ov[1]}), 32'd0);
        rst = 1'b0;
        wait_cyc(4);

        send_frame(0, 8'hA5, 1'b0, 1'b1);
        settle(0);
        check("a5_data", 32'(data0), 32'h0000_00A5);
        check("a5_valid", 32'(valid[0]), 32'd1);
        check("a5_busy", 32'(busy[0]), 32'd0);

        pulse_read(0);
        check("read_ready", 32'(ready[0]), 32'd1);
        check("read_valid", 32'(valid[0]), 32'd0);
        check("read_hold", 32'(data0), 32'h0000_00A5);
        wait_cyc(1);
        check("ready_one_cycle", 32'(ready[0]), 32'd0);

        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        settle(0);
        check("ovr_data", 32'(data0), 32'h0000_0011);
        check("ovr_flag", 32'(ov[0]), 32'd1);
        pulse_read(0);
        check("ovr_clear", 32'({ov[0], valid[0]}), 32'd0);

        send_frame(0, 8'h3C, 1'b0, 1'b0);
        settle(0);
        check("ferr_flag", 32'(fe[0]), 32'd1);
        check("ferr_valid", 32'(valid[0]), 32'd0);
        check("ferr_data", 32'(data0), 32'h0000_0011);

        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
        check("midframe_busy", 32'(busy[0]), 32'd1);
        settle(0);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        check("midreset_state", 32'({data0, valid[0], busy[0], fe[0], pe[0], ov[0]}), 32'd0);
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        settle(0);
        check("after_reset_data", 32'(data0), 32'h0000_005A);
        check("after_reset_flags", 32'({fe[0], pe[0], ov[0]}), 32'd0);
        pulse_read(0);

        send_frame(1, 8'h07, 1'b0, 1'b1);
        settle(1);
        check("par_bad_flag", 32'(pe[1]), 32'd1);
        check("par_bad_noload", 32'({data1, valid[1]}), 32'd0);
        send_frame(1, 8'h07, 1'b1, 1'b1);
        settle(1);
        check("par_good_data", 32'(data1), 32'h0000_0007);
        check("par_good_valid", 32'(valid[1]), 32'd1);
        pulse_read(1);
        check("par_read_clear", 32'({pe[1], valid[1]}), 32'd0);

        fork
            begin rand_sender(0); done0 = 1'b1; end
            begin rand_sender(1); done1 = 1'b1; end
            begin
                while (!(done0 && done1)) begin
                    rd_in[0] = ($urandom_range(0, 15) == 0);
                    rd_in[1] = ($urandom_range(0, 15) == 0);
                    wait_cyc(1);
                end
                rd_in = 2'b00;
            end
        join
        wait_cyc(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
